// File: rtl/servo_pkg.sv
// Shared constants, types and width arithmetic for the servo PWM array.
package servo_pkg;

    localparam int PERIOD_CYC_DEFAULT = 2_000_000;
    localparam int CENTER_CYC_DEFAULT = 150_000;
    localparam int STEP_CYC_DEFAULT   = 160;
    localparam int CMD_W_DEFAULT      = 8;
    localparam int RAMP_STEP_DEFAULT  = 5_000;
    localparam int CNT_W_DEFAULT      = $clog2(PERIOD_CYC_DEFAULT);

    typedef logic [CNT_W_DEFAULT-1:0] width_t;

    // Pulse width for a signed speed command. The most negative code is
    // folded onto its neighbour so the range is symmetric about stop.
    function automatic int cmd_to_width(
        input int cmd_val,
        input int cmd_w,
        input int center,
        input int step
    );
        int lim;
        int c;
        lim = (32'sd1 <<< (cmd_w - 32'sd1)) - 32'sd1;
        c   = cmd_val;
        if (c < -lim) begin
            c = -lim;
        end else begin
            c = cmd_val;
        end
        return center + c * step;
    endfunction

endpackage

// File: rtl/servo_pwm_array_channel.sv
// One servo channel: shadow command, ramped active width and pulse compare.
module servo_channel
    import servo_pkg::*;
#(
    parameter int CMD_W      = CMD_W_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int CENTER_CYC = CENTER_CYC_DEFAULT,
    parameter int STEP_CYC   = STEP_CYC_DEFAULT,
    parameter int RAMP_STEP  = RAMP_STEP_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count,
    input  logic             boundary,
    input  logic             load,
    input  logic             en,
    input  logic             en_q,
    input  logic [CMD_W-1:0] cmd,
    output logic             pwm,
    output logic             ramping
);

    localparam logic [CNT_W-1:0] CENTER_W = CNT_W'(CENTER_CYC);
    localparam logic [CNT_W-1:0] RAMP_W   = CNT_W'(RAMP_STEP);

    logic signed [CMD_W-1:0] cmd_r;
    logic [CNT_W-1:0]        active_r;
    logic [CNT_W-1:0]        target_s;
    logic [CNT_W-1:0]        next_active_s;
    logic                    pwm_r;
    logic                    ramping_r;
    int                      target_int_s;
    int                      diff_s;

    // Target width from the shadow command and the next ramp step toward it.
    always_comb begin
        target_int_s  = cmd_to_width(int'(cmd_r), CMD_W, CENTER_CYC, STEP_CYC);
        target_s      = CNT_W'(target_int_s);
        diff_s        = target_int_s - int'(active_r);
        next_active_s = active_r;
        if ((RAMP_STEP == 0) || ((diff_s <= RAMP_STEP) && (diff_s >= -RAMP_STEP))) begin
            next_active_s = target_s;
        end else if (diff_s > 32'sd0) begin
            next_active_s = active_r + RAMP_W;
        end else begin
            next_active_s = active_r - RAMP_W;
        end
    end

    // Shadow load any time, width update only at the frame boundary, registered compare.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_r     <= '0;
            active_r  <= CENTER_W;
            pwm_r     <= 1'b0;
            ramping_r <= 1'b0;
        end else begin
            if (load) begin
                cmd_r <= cmd;
            end
            if (boundary) begin
                // Disabled channels restart from stop so re-enable ramps from centre.
                active_r <= en ? next_active_s : CENTER_W;
            end
            ramping_r <= (active_r != target_s);
            pwm_r     <= en_q && (count < active_r);
        end
    end

    assign pwm     = pwm_r;
    assign ramping = ramping_r;

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: shared frame timebase, command handshake
// and enable, with one servo_channel per output.
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int PERIOD_CYC = PERIOD_CYC_DEFAULT,
    parameter int CENTER_CYC = CENTER_CYC_DEFAULT,
    parameter int STEP_CYC   = STEP_CYC_DEFAULT,
    parameter int CMD_W      = CMD_W_DEFAULT,
    parameter int RAMP_STEP  = RAMP_STEP_DEFAULT,
    parameter int CNT_W      = $clog2(PERIOD_CYC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [N_CH*CMD_W-1:0] cmd,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [N_CH-1:0]       pwm,
    output logic [N_CH-1:0]       ramping,
    output logic                  frame_start,
    output logic [CNT_W-1:0]      count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             started_r;
    logic             frame_start_r;
    logic             cmd_ready_r;
    logic             en_q_r;
    logic             boundary_s;
    logic             load_s;

    // Next timebase value; the first edge after reset holds 0 so frame_start
    // lines up with count==0 in that cycle.
    always_comb begin
        count_next_s = count_r;
        if (!started_r) begin
            count_next_s = '0;
        end else if (count_r == LAST) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + CNT_W'(1);
        end
    end

    assign boundary_s = (count_r == LAST);
    assign load_s     = cmd_valid && cmd_ready_r;

    // Timebase, registered frame_start / cmd_ready, and enable sampled at the boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r       <= '0;
            started_r     <= 1'b0;
            frame_start_r <= 1'b0;
            cmd_ready_r   <= 1'b0;
            en_q_r        <= 1'b0;
        end else begin
            count_r       <= count_next_s;
            started_r     <= 1'b1;
            frame_start_r <= (count_next_s == '0);
            cmd_ready_r   <= (count_next_s != LAST);
            if (boundary_s) begin
                en_q_r <= en;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        servo_channel #(
            .CMD_W      (CMD_W),
            .CNT_W      (CNT_W),
            .CENTER_CYC (CENTER_CYC),
            .STEP_CYC   (STEP_CYC),
            .RAMP_STEP  (RAMP_STEP)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .count    (count_r),
            .boundary (boundary_s),
            .load     (load_s),
            .en       (en),
            .en_q     (en_q_r),
            .cmd      (cmd[g*CMD_W +: CMD_W]),
            .pwm      (pwm[g]),
            .ramping  (ramping[g])
        );
    end

    assign count       = count_r;
    assign frame_start = frame_start_r;
    assign cmd_ready   = cmd_ready_r;

endmodule
